// File: rtl/cdc_pkg.sv
// Shared types and constants for the cdc_sync_filter block.
//   state_e            : qualifier FSM states
//   MIN_STAGES         : shallowest legal synchroniser depth
//   MIN_STABLE_CYCLES  : smallest legal qualification length
//   stages_ok/stable_ok: parameter legality helpers used at elaboration
package cdc_pkg;

  typedef enum logic [0:0] {
    SETTLED = 1'b0,
    QUALIFY = 1'b1
  } state_e;

  localparam int unsigned MIN_STAGES        = 2;
  localparam int unsigned MIN_STABLE_CYCLES = 1;

  function automatic bit stages_ok(input int unsigned stages);
    return stages >= MIN_STAGES;
  endfunction

  function automatic bit stable_ok(input int unsigned cycles);
    return cycles >= MIN_STABLE_CYCLES;
  endfunction

endpackage

// File: rtl/cdc_sync_filter_if.sv
// Bus bundle for cdc_sync_filter.
//   en, d_in                          : driven by the user (master)
//   d_sync, d_out, changed, rise,
//   fall, stable                      : driven by the filter (slave)
interface cdc_sync_filter_if #(
  parameter int unsigned WIDTH = 10
);

  logic             en;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_sync;
  logic [WIDTH-1:0] d_out;
  logic             changed;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             stable;

  modport master (
    output en, d_in,
    input  d_sync, d_out, changed, rise, fall, stable
  );

  modport slave (
    input  en, d_in,
    output d_sync, d_out, changed, rise, fall, stable
  );

endinterface

// File: rtl/cdc_sync_filter_sync_chain.sv
// Multi-bit flop-chain synchroniser, STAGES flops per bit.
//   clk, rst_n : clock and synchronous active-low reset
//   d          : asynchronous input bus
//   q          : output of the last stage
module sync_chain #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [STAGES-1:0][WIDTH-1:0] stage_d;

  // Shift the bus one stage deeper each cycle; index 0 captures the input.
  always_comb begin
    stage_d = {stage_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/cdc_sync_filter.sv
// Input synchroniser with a stability qualifier. The synchronised bus is
// only forwarded to d_out after it has held one value for STABLE_CYCLES
// consecutive cycles; each update emits per-bit rise/fall pulses.
//   clk, rst_n  : clock and synchronous active-low reset
//   bus.en      : qualifier enable (sync chain always runs)
//   bus.d_in    : asynchronous input bus
//   bus.d_sync  : raw synchroniser output
//   bus.d_out   : qualified bus
//   bus.changed : one-cycle pulse when d_out updates
//   bus.rise    : per-bit 0->1 pulse aligned with changed
//   bus.fall    : per-bit 1->0 pulse aligned with changed
//   bus.stable  : SETTLED and d_sync == d_out (combinational)
module cdc_sync_filter
  import cdc_pkg::*;
#(
  parameter int unsigned WIDTH         = 10,
  parameter int unsigned STAGES        = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  cdc_sync_filter_if.slave  bus
);

  localparam int unsigned     CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam bit              FILTER   = (STABLE_CYCLES > 1);

  // Elaboration-time parameter legality.
  if (!stages_ok(STAGES)) begin : g_bad_stages
    $error("cdc_sync_filter: STAGES must be at least MIN_STAGES");
  end
  if (!stable_ok(STABLE_CYCLES)) begin : g_bad_stable
    $error("cdc_sync_filter: STABLE_CYCLES must be at least 1");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic             changed_q, changed_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  logic [WIDTH-1:0] d_sync;
  logic             diff_out_c;
  logic             match_cand_c;
  logic             cnt_done_c;

  sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_sync_chain (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.d_in),
    .q     (d_sync)
  );

  assign diff_out_c   = (d_sync != d_out_q);
  assign match_cand_c = (d_sync == cand_q);
  assign cnt_done_c   = (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SETTLED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; en low freezes the FSM.
  always_comb begin
    state_d = state_q;
    if (bus.en) begin
      unique case (state_q)
        SETTLED: begin
          if (diff_out_c && FILTER) state_d = QUALIFY;
        end
        QUALIFY: begin
          if (!diff_out_c) begin
            state_d = SETTLED;
          end else if (match_cand_c && cnt_done_c) begin
            state_d = SETTLED;
          end
        end
        default: state_d = SETTLED;
      endcase
    end
  end

  // Datapath/output logic: candidate tracking, counter and update pulses.
  always_comb begin
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    d_out_d   = d_out_q;
    changed_d = 1'b0;
    rise_d    = '0;
    fall_d    = '0;
    if (bus.en) begin
      unique case (state_q)
        SETTLED: begin
          if (diff_out_c) begin
            if (!FILTER) begin
              d_out_d   = d_sync;
              changed_d = 1'b1;
              rise_d    = d_sync & ~d_out_q;
              fall_d    = ~d_sync & d_out_q;
            end else begin
              cand_d = d_sync;
              cnt_d  = CNT_ONE;
            end
          end
        end
        QUALIFY: begin
          if (diff_out_c) begin
            if (!match_cand_c) begin
              // New code mid-qualification: restart the count on it.
              cand_d = d_sync;
              cnt_d  = CNT_ONE;
            end else if (cnt_done_c) begin
              // d_sync equals cand here, so it stands in for the new value.
              d_out_d   = d_sync;
              changed_d = 1'b1;
              rise_d    = d_sync & ~d_out_q;
              fall_d    = ~d_sync & d_out_q;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_q    <= '0;
      cnt_q     <= '0;
      d_out_q   <= '0;
      changed_q <= 1'b0;
      rise_q    <= '0;
      fall_q    <= '0;
    end else begin
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      d_out_q   <= d_out_d;
      changed_q <= changed_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign bus.d_sync  = d_sync;
  assign bus.d_out   = d_out_q;
  assign bus.changed = changed_q;
  assign bus.rise    = rise_q;
  assign bus.fall    = fall_q;
  // Reported stable while reset is held, before registers are known.
  assign bus.stable  = !rst_n || ((state_q == SETTLED) && !diff_out_c);

endmodule

// File: tb/tb_cdc_sync_filter.sv
// Directed bench for cdc_sync_filter: instance A uses the default
// parameters, instance B uses STAGES=3, STABLE_CYCLES=1. Expected updates
// are queued as stimulus is driven and popped when changed pulses.
module tb_cdc_sync_filter;

  typedef struct packed {
    logic [9:0] val;
    logic [9:0] rise;
    logic [9:0] fall;
  } upd_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  upd_t       q_a[$];
  upd_t       q_b[$];
  logic [9:0] exp_a = '0;
  logic [9:0] exp_b = '0;
  upd_t       mon_ua;
  upd_t       mon_ub;
  logic [9:0] seq_b [4];

  always #5 clk = ~clk;

  cdc_sync_filter_if #(.WIDTH(10)) bus_a ();
  cdc_sync_filter_if #(.WIDTH(10)) bus_b ();

  cdc_sync_filter #(.WIDTH(10), .STAGES(2), .STABLE_CYCLES(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  cdc_sync_filter #(.WIDTH(10), .STAGES(3), .STABLE_CYCLES(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [9:0] v);
    upd_t u;
    u.val  = v;
    u.rise = v & ~exp_a;
    u.fall = ~v & exp_a;
    exp_a  = v;
    q_a.push_back(u);
  endtask

  task automatic push_b(input logic [9:0] v);
    upd_t u;
    u.val  = v;
    u.rise = v & ~exp_b;
    u.fall = ~v & exp_b;
    exp_b  = v;
    q_b.push_back(u);
  endtask

  // Scoreboard monitors: every changed pulse must match the next queued update.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus_a.changed === 1'b1) begin
        if (q_a.size() == 0) begin
          chk("a_spurious_changed", 10'(bus_a.changed), 10'd0);
        end else begin
          mon_ua = q_a.pop_front();
          chk("a_sb_d_out", bus_a.d_out, mon_ua.val);
          chk("a_sb_rise", bus_a.rise, mon_ua.rise);
          chk("a_sb_fall", bus_a.fall, mon_ua.fall);
        end
      end else begin
        chk("a_idle_rise", bus_a.rise, 10'd0);
        chk("a_idle_fall", bus_a.fall, 10'd0);
      end
      if (bus_b.changed === 1'b1) begin
        if (q_b.size() == 0) begin
          chk("b_spurious_changed", 10'(bus_b.changed), 10'd0);
        end else begin
          mon_ub = q_b.pop_front();
          chk("b_sb_d_out", bus_b.d_out, mon_ub.val);
          chk("b_sb_rise", bus_b.rise, mon_ub.rise);
          chk("b_sb_fall", bus_b.fall, mon_ub.fall);
        end
      end else begin
        chk("b_idle_rise", bus_b.rise, 10'd0);
        chk("b_idle_fall", bus_b.fall, 10'd0);
      end
    end
  end

  initial begin
    // 1: reset with 0x3FF on the input, then release.
    rst_n       = 1'b0;
    bus_a.en    = 1'b1;
    bus_a.d_in  = 10'h3FF;
    bus_b.en    = 1'b1;
    bus_b.d_in  = 10'h000;
    #1;
    chk("t1_stable_in_reset_t0", 10'(bus_a.stable), 10'd1);
    tick(5);
    chk("t1_rst_d_out", bus_a.d_out, 10'd0);
    chk("t1_rst_d_sync", bus_a.d_sync, 10'd0);
    chk("t1_rst_changed", 10'(bus_a.changed), 10'd0);
    chk("t1_rst_rise", bus_a.rise, 10'd0);
    chk("t1_rst_fall", bus_a.fall, 10'd0);
    chk("t1_rst_stable", 10'(bus_a.stable), 10'd1);
    chk("t1_rst_b_d_out", bus_b.d_out, 10'd0);
    push_a(10'h3FF);
    rst_n = 1'b1;
    tick(1);
    chk("t1_d_sync_edge1", bus_a.d_sync, 10'd0);
    tick(1);
    chk("t1_d_sync_edge2", bus_a.d_sync, 10'h3FF);
    tick(3);
    chk("t1_d_out_edge5", bus_a.d_out, 10'd0);
    tick(1);
    chk("t1_d_out_edge6", bus_a.d_out, 10'h3FF);
    chk("t1_changed_edge6", 10'(bus_a.changed), 10'd1);
    chk("t1_rise_edge6", bus_a.rise, 10'h3FF);
    chk("t1_fall_edge6", bus_a.fall, 10'd0);
    tick(1);
    chk("t1_changed_edge7", 10'(bus_a.changed), 10'd0);
    chk("t1_stable_after", 10'(bus_a.stable), 10'd1);

    // 2: two-cycle glitch on bit 0 is rejected.
    push_a(10'h000);
    bus_a.d_in = 10'h000;
    tick(7);
    chk("t2_settle_zero", bus_a.d_out, 10'd0);
    bus_a.d_in = 10'h001;
    tick(2);
    bus_a.d_in = 10'h000;
    tick(1);
    chk("t2_qualifying_not_stable", 10'(bus_a.stable), 10'd0);
    tick(6);
    chk("t2_d_out_held", bus_a.d_out, 10'd0);
    chk("t2_stable_back", 10'(bus_a.stable), 10'd1);

    // 3: 0x0F0 -> 0x00F, rise and fall on disjoint bits.
    push_a(10'h0F0);
    bus_a.d_in = 10'h0F0;
    tick(7);
    chk("t3_settle_0f0", bus_a.d_out, 10'h0F0);
    push_a(10'h00F);
    bus_a.d_in = 10'h00F;
    tick(5);
    chk("t3_before_update", bus_a.d_out, 10'h0F0);
    tick(1);
    chk("t3_d_out", bus_a.d_out, 10'h00F);
    chk("t3_changed", 10'(bus_a.changed), 10'd1);
    chk("t3_rise", bus_a.rise, 10'h00F);
    chk("t3_fall", bus_a.fall, 10'h0F0);
    tick(1);

    // 4: skewed intermediate 0x005 is skipped, 0x00A lands directly.
    push_a(10'h000);
    bus_a.d_in = 10'h000;
    tick(7);
    chk("t4_settle_zero", bus_a.d_out, 10'd0);
    bus_a.d_in = 10'h005;
    tick(2);
    bus_a.d_in = 10'h00A;
    push_a(10'h00A);
    tick(5);
    chk("t4_before_update", bus_a.d_out, 10'd0);
    tick(1);
    chk("t4_d_out", bus_a.d_out, 10'h00A);
    chk("t4_changed", 10'(bus_a.changed), 10'd1);
    tick(1);

    // 5: en dropped mid-qualification (cnt=2) for 10 cycles.
    push_a(10'h3C0);
    bus_a.d_in = 10'h3C0;
    tick(4);
    bus_a.en = 1'b0;
    tick(10);
    chk("t5_frozen_d_out", bus_a.d_out, 10'h00A);
    chk("t5_frozen_changed", 10'(bus_a.changed), 10'd0);
    chk("t5_frozen_not_stable", 10'(bus_a.stable), 10'd0);
    bus_a.en = 1'b1;
    tick(1);
    chk("t5_resume_edge1", bus_a.d_out, 10'h00A);
    tick(1);
    chk("t5_resume_edge2", bus_a.d_out, 10'h3C0);
    chk("t5_changed", 10'(bus_a.changed), 10'd1);
    tick(1);
    chk("t5_changed_single", 10'(bus_a.changed), 10'd0);

    // 6: STAGES=3, STABLE_CYCLES=1 instance.
    push_b(10'h155);
    bus_b.d_in = 10'h155;
    tick(3);
    chk("t6_d_sync_edge3", bus_b.d_sync, 10'h155);
    chk("t6_d_out_edge3", bus_b.d_out, 10'd0);
    tick(1);
    chk("t6_d_out_edge4", bus_b.d_out, 10'h155);
    chk("t6_changed_edge4", 10'(bus_b.changed), 10'd1);
    chk("t6_rise_edge4", bus_b.rise, 10'h155);
    seq_b = '{10'h2AA, 10'h001, 10'h3FF, 10'h000};
    for (int i = 0; i < 4; i++) begin
      push_b(seq_b[i]);
      bus_b.d_in = seq_b[i];
      tick(1);
    end
    tick(5);
    chk("t6_final_d_out", bus_b.d_out, 10'd0);
    chk("t6_a_untouched", bus_a.d_out, 10'h3C0);

    chk("end_queue_a_empty", 10'(q_a.size()), 10'd0);
    chk("end_queue_b_empty", 10'(q_b.size()), 10'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdc_sync_filter.md
# cdc_sync_filter

Parametrised multi-bit input synchroniser with a stability qualifier. It brings asynchronous or foreign-clock signals (camera VSYNC/HREF, buttons, slow control buses) into the `clk` domain through a configurable-depth flop chain. The synchronised bus reaches the output only after it has held one value for a programmable number of cycles. On each accepted update the block emits per-bit rise and fall pulses, so downstream logic never acts on glitches or on the skewed intermediate codes of a multi-bit transition.

## Interface
- `WIDTH`, default 10: bus width in bits.
- `STAGES`, default 2: synchroniser depth; legal range ≥ 2.
- `STABLE_CYCLES`, default 4: consecutive equal samples required before the output updates; legal range ≥ 1 (1 disables filtering).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `en`  in  1  qualifier enable. Low freezes the FSM, counter and `d_out`; the sync chain keeps running.
- `d_in`  in  WIDTH  asynchronous input bus.
- `d_sync`  out  WIDTH  raw output of the last sync stage.
- `d_out`  out  WIDTH  filtered, qualified bus.
- `changed`  out  1  one-cycle pulse on the cycle `d_out` updates.
- `rise`  out  WIDTH  per-bit 0→1 pulse, aligned with `changed`.
- `fall`  out  WIDTH  per-bit 1→0 pulse, aligned with `changed`.
- `stable`  out  1  high when the FSM is in SETTLED and `d_sync == d_out`; combinational from registers.

## Operation
- Sync chain: STAGES flops per bit, all flops registered on `clk`.
- Candidate register `cand` (WIDTH bits) and counter `cnt`, width `$clog2(STABLE_CYCLES+1)`.
- FSM in SETTLED:
  - If `d_sync != d_out` and STABLE_CYCLES == 1: load `d_out <= d_sync`, pulse `changed`/`rise`/`fall`, stay in SETTLED.
  - If `d_sync != d_out` and STABLE_CYCLES > 1: load `cand <= d_sync`, `cnt <= 1`, go to QUALIFY.
- FSM in QUALIFY:
  - `d_sync == d_out`: glitch rejected; go to SETTLED with no output change and no pulse.
  - `d_sync` differs from both `cand` and `d_out`: `cand <= d_sync`, `cnt <= 1`, stay in QUALIFY (count restarts).
  - `d_sync == cand` and `cnt == STABLE_CYCLES-1`: `d_out <= cand`, pulse outputs, go to SETTLED.
  - Otherwise: `cnt <= cnt + 1`.
- Pulse values on an update: `rise = new & ~old`, `fall = ~new & old`, where old is the previous `d_out`. All pulses are 0 on every other cycle.
- `en` low: state, `cand`, `cnt` and `d_out` hold; pulses are forced to 0. When `en` returns high, evaluation resumes from the held state.

## Timing
- Reset (synchronous, `rst_n` low at an edge):
  - All sync flops, `cand`, `cnt`, `d_out`, `d_sync`, `changed`, `rise` and `fall` go to 0; state goes to SETTLED.
  - `stable` = 1 while reset is held.
  - Reset during QUALIFY aborts the qualification with no pulse.
- `d_sync` latency: `d_in` held steady before edge 1 appears on `d_sync` after edge STAGES.
- `d_out` latency: a steady change appears on `d_out`, with `changed` high, after edge STAGES+STABLE_CYCLES, with `en` high throughout.
- Any `d_sync` value lasting fewer than STABLE_CYCLES cycles never reaches `d_out`.
- Pulses are registered, high for exactly one cycle, and coincide with the first cycle the new `d_out` is visible.
- Back-to-back changes: at most one update per STABLE_CYCLES cycles.

## Structure
- Package `cdc_pkg`:
  - State enum with values SETTLED and QUALIFY.
  - `MIN_STAGES = 2`.
  - Parameter-check constants.
- Elaboration asserts STAGES ≥ MIN_STAGES and STABLE_CYCLES ≥ 1.
- Sub-module `sync_chain` (parameters WIDTH, STAGES; ports `clk`, `rst_n`, `d`, `q`), instantiated once. The qualifier FSM lives in the top module.

## Test plan
All scenarios use WIDTH=10, STAGES=2, STABLE_CYCLES=4 unless stated.
1. Hold `rst_n` low 5 cycles with `d_in`=0x3FF → all outputs 0 and `stable`=1. Release reset → `d_out`=0x3FF after edge 6; `changed`=1 for one cycle with `rise`=0x3FF, `fall`=0.
2. From `d_out`=0, drive `d_in`=0x001 for 2 cycles, then 0 → `d_out` stays 0; `changed`, `rise` and `fall` never assert; `stable` returns to 1.
3. From `d_out`=0x0F0, drive `d_in`=0x00F steady → one update 6 edges later with `rise`=0x00F, `fall`=0x0F0.
4. From `d_out`=0, drive `d_in`=0x005 for 2 cycles, then hold 0x00A → a single update straight to 0x00A, 4 cycles after 0x00A reaches `d_sync`; 0x005 never appears on `d_out`.
5. Mid-QUALIFY (`cnt`=2), drop `en` for 10 cycles with the input steady → no update while `en` is low. Raise `en` → update after 2 more edges with a single `changed` pulse.
6. Instance with STAGES=3, STABLE_CYCLES=1: step `d_in` 0→0x155 → `d_out`=0x155 after edge 4; every 1-cycle-stable change propagates.
